seq_restoring_divider: RTL and testbench

- Sequential unsigned integer divider; the inverse operation of the team's Vedic multiplier datapath.
- Produces one quotient bit per clock using the restoring shift/subtract algorithm.
- Ready/valid handshake on both input and output, so it sits beside the multiplier in the arithmetic unit.
- Used to check multiplier results (a*b / b == a) and to provide a division op.

---
 rtl/seq_restoring_divider_if.sv | 25 ++
 rtl/seq_restoring_divider.sv | 84 ++++++++
 tb/tb_seq_restoring_divider.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for the sequential restoring divider.
// The divider uses the slave modport; the requester uses master.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock, ready/valid on both sides.
// Fixed latency: operands accepted at edge N give out_valid after edge N+WIDTH+1.
module seq_restoring_divider #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic                clk,
  input  logic                rst,
  seq_restoring_divider_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] qreg;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] prem;
  logic             zero_pend;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic             z_res;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // The partial remainder stays below the divisor, so a restored value never
  // sets bit WIDTH; only the WIDTH+1-bit trial needs the extra sign bit.
  assign shifted = {prem, qreg[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      qreg      <= '0;
      dvs       <= '0;
      prem      <= '0;
      zero_pend <= 1'b0;
      q_res     <= '0;
      r_res     <= '0;
      z_res     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            qreg      <= bus.dividend;
            dvs       <= bus.divisor;
            prem      <= '0;
            cnt       <= CNT_W'(WIDTH);
            zero_pend <= (bus.divisor == '0);
            state     <= CALC;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            prem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            qreg <= {qreg[WIDTH-2:0], ~trial[WIDTH]};
            cnt  <= cnt - 1'b1;
          end else begin
            // Results are registered separately so they survive the return to IDLE.
            q_res <= qreg;
            r_res <= prem;
            z_res <= zero_pend;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = q_res;
  assign bus.remainder   = r_res;
  assign bus.div_by_zero = z_res;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider at WIDTH=8: latency, handshake,
// backpressure, divide-by-zero, mid-operation reset, plus reference-model pairs.
module tb_seq_restoring_divider;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full transaction; junk=1 also holds in_valid high with garbage during CALC.
  task automatic run(input logic [W-1:0] dd, input logic [W-1:0] dv,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                     input int stall, input bit junk, input string tag);
    int t;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check({tag, "_accept_rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk); #1;
    bus.in_valid = junk;
    bus.dividend = ~dd;
    bus.divisor  = dv ^ 8'h5a;
    repeat (W) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_quot"},  32'(bus.quotient),  32'(eq));
    check({tag, "_rem"},   32'(bus.remainder), 32'(er));
    check({tag, "_dbz"},   32'(bus.div_by_zero), 32'(ez));
    for (int i = 0; i < stall; i++) begin
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_rdy"},   32'(bus.in_ready),  32'd0);
      check({tag, "_hold_quot"},  32'(bus.quotient),  32'(eq));
      check({tag, "_hold_rem"},   32'(bus.remainder), 32'(er));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_rdy"},   32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    logic [W-1:0] a, b, eq, er;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready",  32'(bus.in_ready),    32'd1);
    check("rst_out_valid", 32'(bus.out_valid),   32'd0);
    check("rst_quot",      32'(bus.quotient),    32'd0);
    check("rst_rem",       32'(bus.remainder),   32'd0);
    check("rst_dbz",       32'(bus.div_by_zero), 32'd0);

    // out_ready while idle has no effect
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("idle_ordy_valid", 32'(bus.out_valid), 32'd0);

    run(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 0, 1'b0, "d200_7");
    run(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 0, 1'b0, "d255_1");
    run(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 0, 1'b0, "d5_9");
    run(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 0, 1'b0, "d255_255");
    run(8'd100, 8'd0,   8'd255, 8'd100, 1'b1, 0, 1'b0, "d100_0");
    run(8'd77,  8'd5,   8'd15,  8'd2,   1'b0, 5, 1'b1, "bp77_5");

    // results persist in IDLE
    @(posedge clk); #1;
    check("persist_quot", 32'(bus.quotient),  32'd15);
    check("persist_rem",  32'(bus.remainder), 32'd2);

    // reset during the 4th CALC cycle
    bus.in_valid = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready",  32'(bus.in_ready),    32'd1);
    check("abort_out_valid", 32'(bus.out_valid),   32'd0);
    check("abort_quot",      32'(bus.quotient),    32'd0);
    check("abort_rem",       32'(bus.remainder),   32'd0);
    check("abort_dbz",       32'(bus.div_by_zero), 32'd0);
    repeat (W + 2) @(posedge clk);
    #1 check("abort_no_pulse", 32'(bus.out_valid), 32'd0);
    run(8'd63, 8'd8, 8'd7, 8'd7, 1'b0, 0, 1'b0, "d63_8");

    // reset wins over a simultaneous in_valid
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd2;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rstwin_rdy", 32'(bus.in_ready), 32'd1);
    repeat (W + 2) @(posedge clk);
    #1 check("rstwin_no_valid", 32'(bus.out_valid), 32'd0);

    // reference-model pairs with random stalls
    for (int n = 0; n < 200; n++) begin
      a = W'($urandom);
      b = (n % 17 == 0) ? '0 : W'($urandom);
      if (b == '0) begin
        eq = '1;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      run(a, b, eq, er, (b == '0), $urandom_range(0, 3), n[0], "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
